lsu_mem_port: RTL and testbench



---
 rtl/lsu_mem_port_pkg.sv | 41 ++++
 rtl/lsu_load_align.sv | 17 +
 rtl/lsu_mem_port.sv | 90 +++++++++
 tb/tb_lsu_mem_port.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_port_pkg: ALU load/store codes, LSU FSM states and lane-enable helpers
package lsu_mem_port_pkg;
  localparam logic [5:0] ALU_LUI  = 6'd0;
  localparam logic [5:0] ALU_JAL  = 6'd1;
  localparam logic [5:0] ALU_JALR = 6'd2;
  localparam logic [5:0] ALU_BEQ  = 6'd3;
  localparam logic [5:0] ALU_BNE  = 6'd4;
  localparam logic [5:0] ALU_BLT  = 6'd5;
  localparam logic [5:0] ALU_BGE  = 6'd6;
  localparam logic [5:0] ALU_BLTU = 6'd7;
  localparam logic [5:0] ALU_BGEU = 6'd8;
  localparam logic [5:0] ALU_LB   = 6'd9;
  localparam logic [5:0] ALU_LH   = 6'd10;
  localparam logic [5:0] ALU_LW   = 6'd11;
  localparam logic [5:0] ALU_LBU  = 6'd12;
  localparam logic [5:0] ALU_LHU  = 6'd13;
  localparam logic [5:0] ALU_SB   = 6'd14;
  localparam logic [5:0] ALU_SH   = 6'd15;
  localparam logic [5:0] ALU_SW   = 6'd16;
  localparam logic [5:0] ALU_ADD  = 6'd17;
  localparam logic [5:0] ALU_NOP  = 6'd63;
  localparam logic [1:0] LSU_IDLE   = 2'd0;
  localparam logic [1:0] LSU_ACCESS = 2'd1;
  localparam logic [1:0] LSU_DONE   = 2'd2;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;
  function automatic logic is_load(input logic [5:0] op);
    return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
  endfunction
  function automatic logic is_store(input logic [5:0] op);
    return op inside {ALU_SB, ALU_SH, ALU_SW};
  endfunction
  function automatic lsu_size_t op_size(input logic [5:0] op);
    return op inside {ALU_LB, ALU_LBU, ALU_SB} ? SZ_B : op inside {ALU_LH, ALU_LHU, ALU_SH} ? SZ_H : SZ_W;
  endfunction
  function automatic logic [3:0] byte_be(input logic [1:0] o);
    return 4'b0001 << o;
  endfunction
  function automatic logic [3:0] half_be(input logic [1:0] o);
    return 4'b0011 << {o[1], 1'b0};
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: lane extract and sign/zero extension of a read word
import lsu_mem_port_pkg::*;
module lsu_load_align (
  input  lsu_size_t   size,
  input  logic        uns,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{offset, 3'b000} +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    data = size == SZ_W ? rdata : size == SZ_H ? {{16{h[15] & ~uns}}, h} : {{24{b[7] & ~uns}}, b};
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: req/ack data-memory port for ALU load/store ops; define MISALIGN_TRAP_EN to trap misaligned half/word accesses
import lsu_mem_port_pkg::*;
module lsu_mem_port #(
  parameter int WAIT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned LAST = (1 << WAIT_W) - 2;
  logic [1:0] state;
  logic [WAIT_W-1:0] cnt;
  lsu_size_t size_d, size_q;
  logic uns_q, load_q, mis, mis_q, err_q, accept, timeout;
  logic [1:0] off_q;
  logic [3:0] be_d;
  logic [31:0] wd_d, ld_q, aligned;
  always_comb begin
    size_d = op_size(alucode);
    accept = state == LSU_IDLE && start && (is_load(alucode) || is_store(alucode));
    be_d = size_d == SZ_W ? 4'hF : size_d == SZ_H ? half_be(addr[1:0]) : byte_be(addr[1:0]);
    wd_d = size_d == SZ_W ? store_data : size_d == SZ_H ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
`ifdef MISALIGN_TRAP_EN
    mis = (size_d == SZ_H && addr[0]) || (size_d == SZ_W && addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    timeout = !mem_ack && cnt == LAST[WAIT_W-1:0];
  end
  lsu_load_align u_align (.size(size_q), .uns(uns_q), .offset(off_q), .rdata(mem_rdata), .data(aligned));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LSU_IDLE;
      cnt <= '0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      size_q <= SZ_B;
      uns_q <= 1'b0;
      load_q <= 1'b0;
      off_q <= '0;
      ld_q <= '0;
      err_q <= 1'b0;
      mis_q <= 1'b0;
    end else case (state)
      LSU_IDLE: if (accept) begin
        state <= mis ? LSU_DONE : LSU_ACCESS;
        cnt <= '0;
        mem_addr <= {addr[31:2], 2'b00};
        mem_be <= be_d;
        mem_we <= is_store(alucode) & ~mis;
        mem_wdata <= wd_d;
        size_q <= size_d;
        uns_q <= alucode == ALU_LBU || alucode == ALU_LHU;
        load_q <= is_load(alucode);
        off_q <= addr[1:0];
        ld_q <= '0;
        err_q <= 1'b0;
        mis_q <= mis;
      end
      LSU_ACCESS: if (mem_ack || timeout) begin
        state <= LSU_DONE;
        ld_q <= mem_ack && load_q ? aligned : '0;
        err_q <= !mem_ack;
      end else cnt <= cnt + 1'b1;
      default: state <= LSU_IDLE;
    endcase
  assign mem_req = state == LSU_ACCESS;
  assign busy = accept || mem_req;
  assign done = state == LSU_DONE;
  assign load_data = ld_q;
  assign bus_err = err_q;
  assign misaligned = mis_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: randomized and directed checks of lsu_mem_port against a byte-lane reference model
module tb_lsu_mem_port;
  import lsu_mem_port_pkg::*;
  localparam int WAIT_W = 3;
  localparam int TMO = (1 << WAIT_W) - 1;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mem_ack = 1'b0;
  logic [5:0] alucode = ALU_NOP;
  logic [31:0] addr = '0, store_data = '0, mem_rdata = '0;
  logic busy, done, bus_err, misaligned, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  lsu_mem_port #(.WAIT_W(WAIT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .alucode(alucode), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .load_data(load_data), .bus_err(bus_err), .misaligned(misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  function automatic int sz_of(input logic [5:0] op);
    return (op == ALU_LB || op == ALU_LBU || op == ALU_SB) ? 1 : (op == ALU_LH || op == ALU_LHU || op == ALU_SH) ? 2 : 4;
  endfunction
  function automatic bit is_st(input logic [5:0] op);
    return op == ALU_SB || op == ALU_SH || op == ALU_SW;
  endfunction
  function automatic bit is_mis(input logic [5:0] op, input logic [31:0] a);
    return TRAP && (int'(a[1:0]) % sz_of(op)) != 0;
  endfunction
  function automatic int lane_of(input logic [5:0] op, input logic [31:0] a);
    int n = sz_of(op);
    return n == 4 ? 0 : (int'(a[1:0]) / n) * n;
  endfunction
  function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [31:0] a);
    return 4'(((1 << sz_of(op)) - 1) << lane_of(op, a));
  endfunction
  function automatic logic [31:0] ref_wd(input logic [5:0] op, input logic [31:0] d);
    int n = sz_of(op);
    return n == 1 ? 32'(d[7:0]) * 32'h01010101 : n == 2 ? 32'(d[15:0]) * 32'h00010001 : d;
  endfunction
  function automatic logic [31:0] ref_ld(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
    int n = sz_of(op);
    logic [31:0] v, m;
    v = rd >> (8 * lane_of(op, a));
    if (n < 4) begin
      m = (32'h1 << (8 * n)) - 32'h1;
      v = v & m;
      if ((op == ALU_LB || op == ALU_LH) && v[8 * n - 1]) v = v | ~m;
    end
    return v;
  endfunction
  task automatic do_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d, input int dly, input logic [31:0] rd);
    bit mis = is_mis(op, a);
    bit st = is_st(op);
    bit err = !mis && (dly < 0 || dly >= TMO);
    int exp_req = mis ? 0 : err ? TMO : dly + 1;
    logic [31:0] exp_ld = (!mis && !err && !st) ? ref_ld(op, a, rd) : 32'h0;
    int req_n = 0, done_at = -1;
    @(negedge clk);
    start = 1'b1; alucode = op; addr = a; store_data = d;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_on_start op=%0d got %b want 1", op, busy); end
    for (int cyc = 1; cyc <= 20 && done_at < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0; mem_ack = 1'b0;
      #1;
      if (done === 1'b1) done_at = cyc;
      else if (mem_req === 1'b1) begin
        req_n++;
        checks++;
        if (mem_addr !== {a[31:2], 2'b00} || mem_be !== ref_be(op, a) || mem_we !== st || (st && mem_wdata !== ref_wd(op, d)) || busy !== 1'b1) begin
          errors++;
          $display("FAIL access_fields op=%0d a=%h got addr=%h be=%b we=%b wd=%h busy=%b want addr=%h be=%b we=%b wd=%h busy=1",
                   op, a, mem_addr, mem_be, mem_we, mem_wdata, busy, {a[31:2], 2'b00}, ref_be(op, a), st, ref_wd(op, d));
        end
        mem_ack = (req_n - 1 == dly);
        mem_rdata = mem_ack ? rd : $urandom;
      end
    end
    checks++;
    if (done_at !== exp_req + 1) begin errors++; $display("FAIL done_latency op=%0d a=%h got %0d want %0d", op, a, done_at, exp_req + 1); end
    checks++;
    if (req_n !== exp_req) begin errors++; $display("FAIL req_cycles op=%0d a=%h got %0d want %0d", op, a, req_n, exp_req); end
    checks++;
    if (load_data !== exp_ld || bus_err !== err || misaligned !== mis || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_outputs op=%0d a=%h got ld=%h err=%b mis=%b busy=%b want ld=%h err=%b mis=%b busy=0",
               op, a, load_data, bus_err, misaligned, busy, exp_ld, err, mis);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL single_done got done=%b req=%b want 0 0", done, mem_req); end
  endtask
  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, done, load_data, bus_err, misaligned, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b ld=%h req=%b we=%b addr=%h be=%b wd=%h want all 0",
               busy, done, load_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    rst = 1'b0;
  endtask
  task automatic test_store_word;
    do_access(ALU_SW, 32'h1000, 32'hDEADBEEF, 0, 32'h0);
  endtask
  task automatic test_load_byte;
    do_access(ALU_LB, 32'h1003, 32'h0, 0, 32'h80FFFFFF);
    do_access(ALU_LBU, 32'h1003, 32'h0, 0, 32'h80FFFFFF);
  endtask
  task automatic test_store_half_wait;
    do_access(ALU_SH, 32'h2002, 32'h0000ABCD, 5, 32'h0);
  endtask
  task automatic test_timeout;
    do_access(ALU_LW, 32'h3000, 32'h0, -1, 32'h0);
  endtask
  task automatic test_reset_abort;
    int seen = 0;
    @(negedge clk);
    start = 1'b1; alucode = ALU_LW; addr = 32'h4000;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_pre_req got %b want 1", mem_req); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_req_drop got req=%b busy=%b want 0 0", mem_req, busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d done pulses want 0", seen); end
    do_access(ALU_LHU, 32'h10, 32'h0, 0, 32'h1234F00D);
  endtask
  task automatic test_misalign;
    do_access(ALU_LW, 32'h1001, 32'h55AA55AA, 0, 32'h11223344);
    do_access(ALU_SH, 32'h2001, 32'h00001234, 1, 32'h0);
  endtask
  task automatic test_non_mem;
    int seen = 0;
    @(negedge clk);
    start = 1'b1; alucode = ALU_ADD; addr = 32'h1000;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL non_mem_busy got %b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1 || mem_req === 1'b1 || busy === 1'b1) seen++;
    end
    start = 1'b0;
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL non_mem_activity got %0d active cycles want 0", seen); end
  endtask
  task automatic test_back_to_back;
    int ndone = 0, bad = 0;
    @(negedge clk);
    start = 1'b1; alucode = ALU_SW; addr = 32'h100; store_data = 32'h01234567;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      #1;
      mem_ack = mem_req;
      if (done === 1'b1) begin
        ndone++;
        if (busy !== 1'b0) bad++;
      end
    end
    start = 1'b0; mem_ack = 1'b0;
    checks++;
    if (ndone !== 3 || bad !== 0) begin errors++; $display("FAIL back_to_back got %0d dones (%0d busy) want 3 (0)", ndone, bad); end
    @(negedge clk);
  endtask
  task automatic test_random;
    logic [5:0] ops [8] = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};
    for (int i = 0; i < 40; i++) begin
      int dly = int'($urandom_range(0, 8));
      do_access(ops[$urandom_range(0, 7)], $urandom, $urandom, dly == 8 ? -1 : dly, $urandom);
    end
  endtask
  initial begin
    test_reset;
    test_store_word;
    test_load_byte;
    test_store_half_wait;
    test_timeout;
    test_reset_abort;
    test_misalign;
    test_non_mem;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
